// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin arbiter sharing one I2C_Controller between N command requesters
module i2c_cmd_arbiter #(
    parameter int N_REQ       = 3,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int GAP_CYC     = 5000
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [N_REQ-1:0]      iREQ,
    input  logic [24*N_REQ-1:0]   iREQ_DATA,
    output logic [N_REQ-1:0]      oGNT,
    output logic [N_REQ-1:0]      oDONE,
    output logic [N_REQ-1:0]      oNACK,
    output logic                  oBUSY,
    output logic [23:0]           oI2C_DATA,
    output logic                  oI2C_GO,
    input  logic                  iI2C_END,
    input  logic                  iI2C_ACK
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, GRANT, START, XFER, CHECK, GAP, FINISH} state_t;

    state_t            state, state_n;
    logic [N_REQ-1:0]  gnt, gnt_n;
    logic [23:0]       data, data_n;
    logic              go, go_n;
    logic [IW-1:0]     rr_ptr, rr_n;
    logic [IW-1:0]     idx, idx_n;
    logic [RW-1:0]     retry_cnt, retry_n;
    logic [TW-1:0]     timer, timer_n;
    logic [GW-1:0]     gap_cnt, gap_n;
    logic              fail, fail_n;
    logic              end_m, end_s, ack_m, ack_s;
    logic [IW-1:0]     pick;
    logic              found;
    logic              timed_out, retry_ok, attempt_failed;
    int                psel;

    // END idles high, so the synchroniser resets to the idle level
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            end_m <= 1'b1;
            end_s <= 1'b1;
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            end_m <= iI2C_END;
            end_s <= end_m;
            ack_m <= iI2C_ACK;
            ack_s <= ack_m;
        end
    end

    // Walk from the highest offset down so the nearest request to rr_ptr wins
    always_comb begin
        int j;
        pick  = rr_ptr;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (iREQ[j]) begin
                pick  = IW'(j);
                found = 1'b1;
            end
        end
    end

    assign psel      = int'(pick);
    assign timed_out = (timer == TW'(TIMEOUT_CYC));
    assign retry_ok  = (retry_cnt < RW'(MAX_RETRY));

    always_comb begin
        state_n        = state;
        gnt_n          = gnt;
        data_n         = data;
        rr_n           = rr_ptr;
        idx_n          = idx;
        retry_n        = retry_cnt;
        timer_n        = timer;
        gap_n          = gap_cnt;
        fail_n         = fail;
        attempt_failed = 1'b0;
        case (state)
            IDLE: begin
                if (|iREQ) state_n = GRANT;
            end
            GRANT: begin
                if (found) begin
                    gnt_n   = N_REQ'(1) << pick;
                    data_n  = iREQ_DATA[24*psel +: 24];
                    idx_n   = pick;
                    retry_n = '0;
                    timer_n = '0;
                    fail_n  = 1'b0;
                    state_n = START;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (timed_out) begin
                    attempt_failed = 1'b1;
                end else begin
                    timer_n = timer + TW'(1);
                    if (!end_s) state_n = XFER;
                end
            end
            XFER: begin
                if (timed_out) begin
                    attempt_failed = 1'b1;
                end else begin
                    timer_n = timer + TW'(1);
                    if (end_s) state_n = CHECK;
                end
            end
            CHECK: begin
                if (ack_s) begin
                    attempt_failed = 1'b1;
                end else begin
                    fail_n  = 1'b0;
                    gnt_n   = '0;
                    state_n = FINISH;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    timer_n = '0;
                    state_n = START;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            FINISH: begin
                rr_n    = (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // NACK and timeout share one retry rule
        if (attempt_failed) begin
            if (retry_ok) begin
                retry_n = retry_cnt + RW'(1);
                gap_n   = '0;
                state_n = GAP;
            end else begin
                fail_n  = 1'b1;
                gnt_n   = '0;
                state_n = FINISH;
            end
        end

        go_n = ((state == START) || (state == XFER)) &&
               ((state_n == START) || (state_n == XFER));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            gnt       <= '0;
            data      <= '0;
            go        <= 1'b0;
            rr_ptr    <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            fail      <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            data      <= data_n;
            go        <= go_n;
            rr_ptr    <= rr_n;
            idx       <= idx_n;
            retry_cnt <= retry_n;
            timer     <= timer_n;
            gap_cnt   <= gap_n;
            fail      <= fail_n;
        end
    end

    assign oGNT      = gnt;
    assign oI2C_DATA = data;
    assign oI2C_GO   = go;
    assign oBUSY     = (state != IDLE);
    assign oDONE     = (state == FINISH) ? (N_REQ'(1) << idx) : '0;
    assign oNACK     = (state == FINISH && fail) ? (N_REQ'(1) << idx) : '0;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - self-checking bench for i2c_cmd_arbiter with a behavioural controller model
module tb_i2c_cmd_arbiter;
    localparam int N_REQ   = 3;
    localparam int MAXR    = 3;
    localparam int TMO     = 100;
    localparam int GAP     = 20;
    localparam int LIMIT   = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [71:0] req_data = '0;
    logic [2:0]  gnt, done, nack;
    logic        busy, go;
    logic [23:0] i2c_data;
    logic        i2c_end = 1'b1;
    logic        i2c_ack = 1'b0;

    i2c_cmd_arbiter #(.N_REQ(N_REQ), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .iCLK(clk), .iRST(rst), .iREQ(req), .iREQ_DATA(req_data),
        .oGNT(gnt), .oDONE(done), .oNACK(nack), .oBUSY(busy),
        .oI2C_DATA(i2c_data), .oI2C_GO(go), .iI2C_END(i2c_end), .iI2C_ACK(i2c_ack)
    );

    always #5 clk = ~clk;

    // Controller model plus GO pulse statistics
    logic model_clr = 1'b0;
    logic stuck = 1'b0;
    logic perm_nack = 1'b0;
    int   nack_first = 0;
    int   m_state = 0, m_cnt = 0, xfer_cnt = 0;
    int   go_rises = 0, low_run = 0, high_run = 0;
    int   min_low = 1000000, min_high = 1000000, max_high = 0;
    logic go_d = 1'b0;

    always @(posedge clk) begin
        go_d <= go;
        if (go && !go_d) begin
            go_rises <= go_rises + 1;
            if (go_rises > 0 && low_run < min_low) min_low <= low_run;
            high_run <= 1;
        end else if (go) begin
            high_run <= high_run + 1;
        end
        if (!go && go_d) begin
            if (high_run < min_high) min_high <= high_run;
            if (high_run > max_high) max_high <= high_run;
            low_run <= 1;
        end else if (!go) begin
            low_run <= low_run + 1;
        end
        case (m_state)
            0: if (go && i2c_end && !stuck) begin m_cnt <= 0; m_state <= 1; end
            1: begin
                if (!go) m_state <= 0;
                else if (m_cnt == 3) begin i2c_end <= 1'b0; m_cnt <= 0; m_state <= 2; end
                else m_cnt <= m_cnt + 1;
            end
            2: begin
                if (!go) begin i2c_end <= 1'b1; m_state <= 0; end
                else if (m_cnt == 8) begin
                    i2c_ack  <= perm_nack || (xfer_cnt < nack_first);
                    xfer_cnt <= xfer_cnt + 1;
                    i2c_end  <= 1'b1;
                    m_state  <= 3;
                end else m_cnt <= m_cnt + 1;
            end
            default: if (!go) m_state <= 0;
        endcase
        if (model_clr) begin
            go_rises <= 0; xfer_cnt <= 0;
            min_low <= 1000000; min_high <= 1000000; max_high <= 0;
        end
        if (rst) begin
            m_state <= 0; i2c_end <= 1'b1; i2c_ack <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_gnt();
        for (int c = 0; c < LIMIT && gnt == 3'b000; c++) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int c = 0; c < LIMIT && done == 3'b000; c++) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < LIMIT && busy; c++) @(negedge clk);
        chk("idle", 32'(busy), 32'd0);
    endtask

    task automatic clear_model();
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [23:0] d0, d1, d2;
        int          nack_first;
        bit          perm;
        logic [2:0]  exp_gnt;
        logic [23:0] exp_data;
        bit          exp_nack;
        int          exp_gos;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // rr_ptr enters the table at 1 (left there by the latency sequence)
        vecs[0] = '{3'b001, 24'h729803, 24'h0, 24'h0, 0, 1'b0, 3'b001, 24'h729803, 1'b0, 1};
        vecs[1] = '{3'b010, 24'h0, 24'h123456, 24'h0, 0, 1'b0, 3'b010, 24'h123456, 1'b0, 1};
        vecs[2] = '{3'b100, 24'h0, 24'h0, 24'hA5A5A5, 2, 1'b0, 3'b100, 24'hA5A5A5, 1'b0, 3};
        vecs[3] = '{3'b001, 24'h0F0F0F, 24'h0, 24'h0, 0, 1'b1, 3'b001, 24'h0F0F0F, 1'b1, 4};
        vecs[4] = '{3'b110, 24'h0, 24'hBEEF01, 24'hDEAD02, 0, 1'b0, 3'b010, 24'hBEEF01, 1'b0, 1};
        vecs[5] = '{3'b101, 24'h111111, 24'h0, 24'h222222, 0, 1'b0, 3'b100, 24'h222222, 1'b0, 1};
        vecs[6] = '{3'b011, 24'h333333, 24'h444444, 24'h0, 0, 1'b0, 3'b001, 24'h333333, 1'b0, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_nack", 32'(nack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_data", 32'(i2c_data), 32'd0);

        // Grant/GO latency and data latching
        req_data = {24'h0, 24'h0, 24'hABCDEF};
        req = 3'b001;
        @(negedge clk);
        chk("lat_gnt_early", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("lat_gnt", 32'(gnt), 32'b001);
        chk("lat_data", 32'(i2c_data), 32'hABCDEF);
        chk("lat_go_early", 32'(go), 32'd0);
        @(negedge clk);
        chk("lat_go", 32'(go), 32'd1);
        req_data = '0;
        @(negedge clk);
        chk("data_latched", 32'(i2c_data), 32'hABCDEF);
        wait_done();
        chk("lat_done", 32'(done), 32'b001);
        req = 3'b000;
        wait_idle();

        for (int i = 0; i < 7; i++) begin
            req_data   = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
            nack_first = vecs[i].nack_first;
            perm_nack  = vecs[i].perm;
            stuck      = 1'b0;
            clear_model();
            req = vecs[i].req;
            wait_gnt();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            chk($sformatf("v%0d_data", i), 32'(i2c_data), 32'(vecs[i].exp_data));
            wait_done();
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_gnt));
            chk($sformatf("v%0d_nack", i), 32'(nack), vecs[i].exp_nack ? 32'(vecs[i].exp_gnt) : 32'd0);
            chk($sformatf("v%0d_gnt_at_done", i), 32'(gnt), 32'd0);
            req = 3'b000;
            @(negedge clk);
            chk($sformatf("v%0d_done_1cyc", i), 32'(done), 32'd0);
            wait_idle();
            chk($sformatf("v%0d_gos", i), 32'(go_rises), 32'(vecs[i].exp_gos));
            if (vecs[i].exp_gos > 1)
                chk($sformatf("v%0d_gap", i), 32'(min_low >= GAP), 32'd1);
        end
        perm_nack = 1'b0;
        nack_first = 0;

        // Timeout: END never falls
        stuck = 1'b1;
        clear_model();
        req = 3'b001;
        wait_done();
        chk("tmo_done", 32'(done), 32'b001);
        chk("tmo_nack", 32'(nack), 32'b001);
        req = 3'b000;
        wait_idle();
        chk("tmo_gos", 32'(go_rises), 32'(MAXR + 1));
        chk("tmo_min_high", 32'(min_high), 32'(TMO));
        chk("tmo_max_high", 32'(max_high), 32'(TMO));
        stuck = 1'b0;

        // Reset mid-XFER; rr_ptr is 1 here, so a fresh grant to 0 shows it was cleared
        clear_model();
        req = 3'b010;
        for (int c = 0; c < LIMIT && m_state != 2; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("rx_go_before", 32'(go), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 3'b011;
        chk("rx_go", 32'(go), 32'd0);
        chk("rx_gnt", 32'(gnt), 32'd0);
        chk("rx_busy", 32'(busy), 32'd0);
        wait_gnt();
        chk("rx_regrant", 32'(gnt), 32'b001);
        wait_done();
        chk("rx_done", 32'(done), 32'b001);
        req = 3'b000;
        wait_idle();

        // Round-robin with all requests held
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
        req_data = {24'h300003, 24'h200002, 24'h100001};
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_done();
            chk($sformatf("rr%0d_done", i), 32'(done), 32'(3'b001 << (i % 3)));
            @(negedge clk);
            chk($sformatf("rr%0d_pulse", i), 32'(done), 32'd0);
        end
        req = 3'b000;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
